control_multiplicador: RTL and testbench

- Moore FSM that sequences the shift-add multiplier datapath built from three RegistroUniversal instances:
  - A: accumulator, ANCHO bits.
  - Q: multiplier, ANCHO bits.
  - P: iteration counter, 4 bits.
- Drives each register's 2-bit Control, the carry flip-flop controls and the start/done handshake.
- Contains an internal watchdog that ends a run with an error if P never reaches zero.

---
 rtl/control_multiplicador.sv | 67 ++++++
 tb/tb_control_multiplicador.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/control_multiplicador.sv
// control_multiplicador: Moore sequencer for the shift-add multiplier datapath, with an iteration watchdog.
module control_multiplicador #(
  parameter int ANCHO  = 8,
  parameter int ITER_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       Q0,
  input  logic       P_zero,
  output logic [1:0] ControlA,
  output logic [1:0] ControlQ,
  output logic [1:0] ControlP,
  output logic       carry_ld,
  output logic       carry_clr,
  output logic       busy,
  output logic       done,
  output logic       error
);
  typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, SHIFT, CHECK, DONE} state_t;
  state_t state, next;
  logic [ITER_W-1:0] wd;
  logic err_set, wd_hit;
  assign wd_hit = (wd == ITER_W'(ANCHO));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wd    <= '0;
      error <= 1'b0;
    end else begin
      state <= next;
      if (state == LOAD) begin
        wd    <= '0;
        error <= 1'b0;
      end else if (state == SHIFT && wd != '1) wd <= wd + 1'b1;
      if (err_set) error <= 1'b1;
    end
  end
  // abort outranks every in-run transition; IDLE and DONE ignore it
  always_comb begin
    next    = IDLE;
    err_set = 1'b0;
    case (state)
      IDLE:  next = start ? LOAD : IDLE;
      LOAD:  next = abort ? IDLE : TEST;
      TEST:  next = abort ? IDLE : (Q0 ? ADD : SHIFT);
      ADD:   next = abort ? IDLE : SHIFT;
      SHIFT: next = abort ? IDLE : CHECK;
      CHECK: begin
        next    = abort ? IDLE : ((P_zero || wd_hit) ? DONE : TEST);
        err_set = !abort && !P_zero && wd_hit;
      end
      DONE:    next = start ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    ControlA  = state == ADD ? 2'b00 : state == SHIFT ? 2'b01 : state == LOAD ? 2'b11 : 2'b10;
    ControlQ  = state == SHIFT ? 2'b01 : state == LOAD ? 2'b11 : 2'b10;
    ControlP  = state == SHIFT ? 2'b10 : state == LOAD ? 2'b11 : 2'b00;
    carry_ld  = state == ADD;
    carry_clr = state == LOAD || state == SHIFT;
    busy      = state == LOAD || state == TEST || state == ADD || state == SHIFT || state == CHECK;
    done      = state == DONE;
  end
endmodule

// File: tb/tb_control_multiplicador.sv
// tb_control_multiplicador: scoreboard bench driving the controller with a behavioural shift-add datapath.
module tb_control_multiplicador;
  logic clk = 0, rst = 0, start = 0, abort = 0, Q0, P_zero;
  logic [1:0] ControlA, ControlQ, ControlP;
  logic carry_ld, carry_clr, busy, done, error;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  control_multiplicador #(.ANCHO(8), .ITER_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .Q0(Q0), .P_zero(P_zero),
    .ControlA(ControlA), .ControlQ(ControlQ), .ControlP(ControlP),
    .carry_ld(carry_ld), .carry_clr(carry_clr), .busy(busy), .done(done), .error(error)
  );
  logic [7:0] a = 0, q = 0, m = 0, q_in = 0;
  logic c = 0, kill = 0;
  logic [3:0] p = 0;
  logic [8:0] sum;
  assign sum = {1'b0, a} + {1'b0, m};
  assign Q0 = q[0];
  assign P_zero = (p == 4'd0) && !kill;
  always @(posedge clk) begin
    if (ControlA == 2'b11) a <= 8'd0;
    else if (ControlA == 2'b00) a <= sum[7:0];
    else if (ControlA == 2'b01) a <= {c, a[7:1]};
    if (ControlQ == 2'b11) q <= q_in;
    else if (ControlQ == 2'b01) q <= {a[0], q[7:1]};
    if (carry_clr) c <= 1'b0;
    else if (carry_ld) c <= sum[8];
    if (ControlP == 2'b11) p <= 4'd8;
    else if (ControlP == 2'b10) p <= p - 4'd1;
  end
  typedef struct {int busy_n; int adds; int shifts; int err; int prod;} exp_t;
  exp_t sb[$];
  task automatic chk(input string n, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp_v, $time);
    end
  endtask
  function automatic exp_t mk(input logic [7:0] mm, input logic [7:0] qq, input logic k);
    exp_t e;
    e.busy_n = 1;
    e.adds = 0;
    for (int i = 0; i < 8; i++) begin
      e.busy_n += 3 + int'(qq[i]);
      e.adds += int'(qq[i]);
    end
    e.shifts = 8;
    e.err = int'(k);
    e.prod = int'(mm) * int'(qq);
    return e;
  endfunction
  int cnt = 0, nadd = 0, nsh = 0;
  logic done_q = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      if (ControlP == 2'b11) begin
        cnt = 1;
        nadd = 0;
        nsh = 0;
      end else begin
        cnt++;
        nadd += int'(carry_ld);
        nsh += int'(ControlP == 2'b10);
      end
    end
    if (done && !done_q) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("busy_cycles", cnt, e.busy_n);
        chk("add_cycles", nadd, e.adds);
        chk("shift_cycles", nsh, e.shifts);
        chk("error_flag", int'(error), e.err);
        chk("product", int'({a, q}), e.prod);
      end
    end
    done_q = done;
  end
  task automatic wait_done();
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 0, 1);
  endtask
  task automatic go(input logic [7:0] mm, input logic [7:0] qq, input logic k, input bit hold);
    m = mm;
    q_in = qq;
    kill = k;
    sb.push_back(mk(mm, qq, k));
    start = 1;
    @(posedge clk);
    #1 if (!hold) start = 0;
    wait_done();
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ControlA", int'(ControlA), 2);
    chk("rst_ControlQ", int'(ControlQ), 2);
    chk("rst_ControlP", int'(ControlP), 0);
    chk("rst_carry_ld", int'(carry_ld), 0);
    chk("rst_carry_clr", int'(carry_clr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    rst = 1;
    @(posedge clk);
    #1;
    go(8'd13, 8'h00, 0, 0);
    go(8'd13, 8'hFF, 0, 0);
    go(8'd13, 8'hA5, 0, 0);
    for (int i = 0; i < 8; i++) go(8'($urandom), 8'($urandom), 0, 0);
    go(8'($urandom), 8'($urandom), 1, 0);
    go(8'd200, 8'h3C, 0, 0);
    go(8'd7, 8'h81, 0, 1);
    repeat (10) begin
      @(negedge clk);
      chk("hold_done", int'(done), 1);
      chk("hold_no_load", int'(ControlP), 0);
    end
    start = 0;
    @(posedge clk);
    #1;
    chk("release_done", int'(done), 0);
    chk("release_busy", int'(busy), 0);
    sb.push_back(mk(m, q_in, 0));
    start = 1;
    @(posedge clk);
    #1;
    chk("reraise_load", int'(ControlP), 3);
    start = 0;
    wait_done();
    @(posedge clk);
    #1;
    m = 8'd9;
    q_in = 8'h01;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 20 && !carry_ld; i++) @(negedge clk);
    chk("abort_reach_add", int'(carry_ld), 1);
    abort = 1;
    @(posedge clk);
    #1 abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ControlA", int'(ControlA), 2);
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle", int'(busy | done), 0);
    end
    go(8'd9, 8'h01, 0, 0);
    m = 8'd5;
    q_in = 8'hF0;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (4) @(posedge clk);
    #3 rst = 0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ControlA", int'(ControlA), 2);
    chk("midrst_ControlP", int'(ControlP), 0);
    chk("midrst_error", int'(error), 0);
    @(negedge clk);
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_idle", int'(busy | done), 0);
    end
    go(8'($urandom), 8'($urandom), 0, 0);
    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
